// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the bit-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach WIDTH, so it needs $clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full adder processes the operands LSB first
// over WIDTH cycles, then pulses done for one cycle with sum/cout/ovf held.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last_bit;

    assign accept   = start && (state != RUN);
    assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

    fa_bit u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            sum_sh <= '0;
            carry  <= sub;
            cnt    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
            carry  <= fa_carry;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                cout <= fa_carry;
                ovf  <= carry ^ fa_carry;
            end
        end
    end

    assign sum = sum_sh;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): expected results are queued
// at each accepted start and compared when done pulses.
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    exp_t sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t         e;
        logic [W-1:0] yy;
        logic [W:0]   r;
        yy     = s ? ~y : y;
        r      = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
        return e;
    endfunction

    // Scoreboard pop on every done pulse
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_done++;
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                $display("op done: sum=%02h cout=%0d ovf=%0d (exp %02h %0d %0d)",
                         sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
        end
    end

    // Caller is just after a negedge. Drives one operation, optionally pokes
    // start mid-RUN with other operands, and checks latency and busy length.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input bit poke);
        int k;
        int busy_cnt;
        int done_before;
        bit seen;
        a = x; b = y; sub = s; start = 1'b1;
        sb.push_back(model(x, y, s));
        done_before = n_done;
        busy_cnt = 0;
        seen = 0;
        k = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            k = i;
            if (busy) busy_cnt++;
            if (done) seen = 1;
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            if (poke && i == 4) start = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency_cycles", 32'(k), 32'(W + 1));
        chk("busy_cycles", 32'(busy_cnt), 32'(W));
        repeat (3) @(negedge clk);
        chk("one_done_pulse", 32'(n_done - done_before), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int dcount;
        int dtimes[$];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // First start accepted right after reset release
        do_op(8'h5A, 8'h33, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h10, 8'h20, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 1'b0);
        do_op(8'h7F, 8'h7F, 1'b0, 1'b1);
        chk("hold_sum_idle", 32'(sum), 32'hFE);
        for (int r = 0; r < 4; r++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

        // Abort mid-RUN
        dcount = n_done;
        a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout_ovf", 32'({cout, ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(n_done - dcount), 32'd0);
        do_op(8'h01, 8'h01, 1'b0, 1'b0);

        // Start held high: one result every W+1 cycles
        a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
        repeat (3) sb.push_back(model(8'h01, 8'h02, 1'b0));
        for (int i = 1; i <= 40 && dtimes.size() < 3; i++) begin
            @(negedge clk);
            if (done) begin
                dtimes.push_back(i);
                if (dtimes.size() == 3) start = 1'b0;
            end
        end
        chk("bb_done_count", 32'(dtimes.size()), 32'd3);
        if (dtimes.size() == 3) begin
            chk("bb_first", 32'(dtimes[0]), 32'(W + 1));
            chk("bb_period1", 32'(dtimes[1] - dtimes[0]), 32'(W + 1));
            chk("bb_period2", 32'(dtimes[2] - dtimes[1]), 32'(W + 1));
        end
        repeat (3) @(negedge clk);
        chk("bb_idle", 32'(busy), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one operation; sampled on clk.
REQ-005 SHALL have port sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 SHALL have port a  input  WIDTH  first operand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  second operand; sampled with start.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  single-cycle pulse when the result is complete.
REQ-010 SHALL have port sum  output  WIDTH  result, valid from done until the next accepted start.
REQ-011 SHALL have port cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 SHALL have port ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-013 SHALL compute the result bit-serially, LSB first, using exactly one one-bit full-adder instance, with a one-bit carry register between cycles.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; the encoding is internal.
REQ-015 IDLE or DONE with start=1 SHALL, at that edge, load shift register A=a, load shift register B=(sub ? ~b : b), set carry register = sub, clear the bit counter, clear the sum register, and go to RUN.
REQ-016 In RUN, each edge SHALL shift the full-adder sum bit into the MSB of the sum register (right shift), store the full-adder carry into the carry register, shift A and B right, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles, and the edge processing bit WIDTH-1 SHALL go to DONE.
REQ-018 done SHALL be high for exactly the one cycle spent in DONE; with no start, DONE SHALL go to IDLE next edge.
REQ-019 Latency SHALL be WIDTH+1 cycles from the start-sampling edge to the edge that ends the done cycle; back-to-back start during DONE SHALL be accepted, giving one operation per WIDTH+1 cycles.
REQ-020 busy SHALL equal (state == RUN).
REQ-021 start asserted during RUN SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-022 On the final RUN edge: cout SHALL capture the carry out of bit WIDTH-1, and ovf SHALL capture (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 sum, cout and ovf SHALL hold their values through DONE and IDLE until the next accepted start.
REQ-024 Changes to a, b and sub after the start edge SHALL NOT affect the operation in progress.

Reset
REQ-025 rst=1 SHALL immediately force the state to IDLE and clear busy, done, sum, cout, ovf, the counter, the carry register and the shift registers.
REQ-026 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-027 The first start SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-028 State encoding constants and the counter width, $clog2(WIDTH+1), SHALL be defined in the shared package serial_add_pkg.
REQ-029 The one-bit adder SHALL be a separate sub-module, fa_bit (inputs a, b, c; outputs sum, carry), instantiated once.
REQ-030 The implementation SHALL contain no WIDTH-wide combinational adder.

Verification (WIDTH=8)
REQ-031 add 0x5A + 0x33 -> done 9 cycles after the start edge, sum=0x8D, cout=0, ovf=1.
REQ-032 add 0xFF + 0x01 -> sum=0x00, cout=1, ovf=0; busy high for exactly 8 cycles.
REQ-033 sub 0x10 - 0x20 -> sum=0xF0, cout=0, ovf=0; sub 0x80 - 0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-034 start pulsed mid-RUN with different operands -> the original result is unchanged and exactly one done pulse occurs.
REQ-035 rst asserted at RUN cycle 4 -> all outputs 0 immediately, no done; a fresh start of 0x01 + 0x01 afterwards -> sum=0x02.
REQ-036 start held high continuously with operands 0x01 + 0x02 -> a done pulse every 9 cycles, each with sum=0x03.
